sdm_sample_feeder: RTL and testbench

- Upstream stage of the 16-bit registered accumulator adder in the sigma-delta DAC.
- Accepts signed PCM samples over a valid/ready handshake and buffers them in a small FIFO.
- Holds each sample for OSR clock cycles as an offset-binary value on operand a, and passes the adder's fed-back sum to operand b.
- Detects and counts FIFO underruns at sample boundaries.

---
 rtl/sdm_sample_feeder.sv | 86 ++++++++
 tb/tb_sdm_sample_feeder.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdm_sample_feeder.sv
// Sample feeder for the sigma-delta accumulator: buffers PCM samples in a small
// FIFO and presents one offset-binary sample on operand a every OSR clocks.
module sdm_sample_feeder #(
    parameter int W                = 16,
    parameter int OSR_LOG2         = 6,
    parameter int DEPTH_LOG2       = 2,
    parameter int MUTE_ON_UNDERRUN = 1
) (
    input  logic         clck,
    input  logic         rst_n,
    input  logic         en,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [W-1:0] s_data,
    input  logic [W-1:0] acc_sum,
    output logic [W-1:0] a,
    output logic [W-1:0] b,
    output logic         s_cin,
    output logic         sample_tick,
    input  logic         clr_status,
    output logic         underrun,
    output logic [7:0]   underrun_cnt
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [W-1:0]          MID     = {1'b1, {(W-1){1'b0}}};
    localparam logic [OSR_LOG2-1:0]   PH_ONE  = 1;
    localparam logic [OSR_LOG2-1:0]   PH_LAST = '1;
    localparam logic [DEPTH_LOG2:0]   PTR_ONE = 1;

    logic [DEPTH-1:0][W-1:0]  mem;
    logic [DEPTH_LOG2:0]      wr_ptr, rd_ptr;
    logic [OSR_LOG2-1:0]      phase;
    logic                     full, empty, push, pop_evt, take;

    // Extra pointer MSB distinguishes full from empty when the low bits match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                     (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
    assign s_ready = !full;
    assign push    = s_valid && !full;
    assign pop_evt = en && (phase == PH_LAST);
    assign take    = pop_evt && !empty;

    assign b     = acc_sum;
    assign s_cin = 1'b0;

    always_ff @(posedge clck) begin
        if (push)
            mem[wr_ptr[DEPTH_LOG2-1:0]] <= s_data;
    end

    always_ff @(posedge clck or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            phase        <= '0;
            a            <= MID;
            sample_tick  <= 1'b0;
            underrun     <= 1'b0;
            underrun_cnt <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (en)
                phase <= phase + PH_ONE;
            sample_tick <= pop_evt;

            // A push on the same edge lands behind the read, so no bypass.
            if (take) begin
                a      <= mem[rd_ptr[DEPTH_LOG2-1:0]] ^ MID;
                rd_ptr <= rd_ptr + PTR_ONE;
            end else if (pop_evt && (MUTE_ON_UNDERRUN != 0)) begin
                a <= MID;
            end

            if (clr_status) begin
                underrun     <= 1'b0;
                underrun_cnt <= '0;
            end else if (pop_evt && empty) begin
                underrun <= 1'b1;
                if (underrun_cnt != 8'hFF)
                    underrun_cnt <= underrun_cnt + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_sdm_sample_feeder.sv
// Bench for sdm_sample_feeder with OSR=4: mute and hold variants driven in
// parallel and compared against a queue-based sample/phase model.
module tb_sdm_sample_feeder;
    localparam int W = 16;

    logic          clck = 1'b0, rst_n = 1'b0, en = 1'b0, s_valid = 1'b0, clr_status = 1'b0;
    logic [W-1:0]  s_data = '0, acc_sum = '0;

    logic          s_ready1, s_cin1, tick1, ur1;
    logic [W-1:0]  a1, b1;
    logic [7:0]    cnt1;
    logic          s_ready0, s_cin0, tick0, ur0;
    logic [W-1:0]  a0, b0;
    logic [7:0]    cnt0;

    sdm_sample_feeder #(.W(W), .OSR_LOG2(2), .DEPTH_LOG2(2), .MUTE_ON_UNDERRUN(1)) dut_mute (
        .clck(clck), .rst_n(rst_n), .en(en), .s_valid(s_valid), .s_ready(s_ready1),
        .s_data(s_data), .acc_sum(acc_sum), .a(a1), .b(b1), .s_cin(s_cin1),
        .sample_tick(tick1), .clr_status(clr_status), .underrun(ur1), .underrun_cnt(cnt1));

    sdm_sample_feeder #(.W(W), .OSR_LOG2(2), .DEPTH_LOG2(2), .MUTE_ON_UNDERRUN(0)) dut_hold (
        .clck(clck), .rst_n(rst_n), .en(en), .s_valid(s_valid), .s_ready(s_ready0),
        .s_data(s_data), .acc_sum(acc_sum), .a(a0), .b(b0), .s_cin(s_cin0),
        .sample_tick(tick0), .clr_status(clr_status), .underrun(ur0), .underrun_cnt(cnt0));

    always #5 clck = ~clck;

    int checks = 0;
    int errors = 0;

    // Reference model: a queue of pending samples and an integer phase 0..3.
    logic [W-1:0] mq[$];
    int           m_phase, m_cnt;
    logic [W-1:0] m_a1, m_a0, m_v;
    logic         m_tick, m_ur, m_acc, m_pe, m_urev;

    always @(posedge clck or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_phase = 0; m_cnt = 0;
            m_a1 = 16'h8000; m_a0 = 16'h8000;
            m_tick = 0; m_ur = 0;
        end else begin
            m_acc  = s_valid && (mq.size() < 4);
            m_pe   = en && (m_phase == 3);
            m_urev = 0;
            if (m_pe) begin
                if (mq.size() > 0) begin
                    m_v  = mq.pop_front();
                    m_a1 = m_v ^ 16'h8000;
                    m_a0 = m_a1;
                end else begin
                    m_a1   = 16'h8000;
                    m_urev = 1;
                end
            end
            m_tick = m_pe;
            if (m_acc) mq.push_back(s_data);
            if (clr_status) begin
                m_ur = 0; m_cnt = 0;
            end else if (m_urev) begin
                m_ur = 1;
                if (m_cnt < 255) m_cnt++;
            end
            if (en) m_phase = (m_phase + 1) % 4;
        end
    end

    function automatic logic [53:0] exp_vec();
        logic rdy;
        rdy = (mq.size() < 4);
        return {m_a1, m_tick, rdy, m_ur, 8'(m_cnt), m_a0, m_tick, rdy, m_ur, 8'(m_cnt)};
    endfunction

    function automatic logic [53:0] obs_vec();
        return {a1, tick1, s_ready1, ur1, cnt1, a0, tick0, s_ready0, ur0, cnt0};
    endfunction

    task automatic step();
        @(posedge clck);
        @(negedge clck);
    endtask

    task automatic do_reset();
        @(negedge clck);
        rst_n = 0; en = 0; s_valid = 0; clr_status = 0;
        step();
        rst_n = 1;
    endtask

    task automatic test_reset();
        en = 1;
        for (int i = 0; i < 14; i++) begin
            s_valid = (i >= 9);
            s_data  = 16'(32'h3000 + i);
            step();
        end
        #2 rst_n = 0;
        #1;
        checks++;
        if ({a1, a0} !== {16'h8000, 16'h8000}) begin
            errors++; $display("FAIL reset_a: got %h/%h want 8000/8000", a1, a0);
        end
        checks++;
        if ({s_ready1, ur1, cnt1, tick1} !== {1'b1, 1'b0, 8'd0, 1'b0}) begin
            errors++; $display("FAIL reset_status: got rdy=%b ur=%b cnt=%0d tick=%b want 1 0 0 0",
                               s_ready1, ur1, cnt1, tick1);
        end
        checks++;
        if ({s_ready0, ur0, cnt0, tick0} !== {1'b1, 1'b0, 8'd0, 1'b0}) begin
            errors++; $display("FAIL reset_status_hold: got rdy=%b ur=%b cnt=%0d tick=%b want 1 0 0 0",
                               s_ready0, ur0, cnt0, tick0);
        end
        en = 0; s_valid = 0;
        @(negedge clck);
        rst_n = 1;
    endtask

    task automatic test_ordered();
        logic [W-1:0] vals [4];
        logic [W-1:0] want [4];
        logic [W-1:0] got[$];
        vals = '{16'h0000, 16'h7FFF, 16'h8000, 16'hFFFF};
        want = '{16'h8000, 16'hFFFF, 16'h0000, 16'h7FFF};
        for (int i = 0; i < 4; i++) begin
            s_valid = 1; s_data = vals[i];
            checks++;
            if (s_ready1 !== 1'b1) begin
                errors++; $display("FAIL ordered_ready: push %0d got %b want 1", i, s_ready1);
            end
            step();
        end
        s_valid = 0;
        checks++;
        if (s_ready1 !== 1'b0) begin
            errors++; $display("FAIL ordered_full: got %b want 0", s_ready1);
        end
        en = 1;
        for (int i = 0; i < 16; i++) begin
            step();
            if (tick1) got.push_back(a1);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL ordered_model: cyc %0d got %h want %h", i, obs_vec(), exp_vec());
            end
        end
        checks++;
        if (got.size() != 4) begin
            errors++; $display("FAIL ordered_ticks: got %0d want 4", got.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got[i] !== want[i]) begin
                    errors++; $display("FAIL ordered_a: sample %0d got %h want %h", i, got[i], want[i]);
                end
            end
        end
    endtask

    task automatic test_full_pop();
        do_reset();
        s_valid = 1;
        for (int i = 0; i < 4; i++) begin
            s_data = 16'($urandom);
            step();
        end
        en = 1;
        for (int i = 0; i < 8; i++) begin
            s_data = 16'($urandom);
            step();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL full_pop_model: cyc %0d got %h want %h", i, obs_vec(), exp_vec());
            end
            if (i == 3) begin
                checks++;
                if ({tick1, s_ready1} !== 2'b11) begin
                    errors++; $display("FAIL full_pop_ready: got tick=%b rdy=%b want 1 1", tick1, s_ready1);
                end
            end
        end
        s_valid = 0; en = 0;
    endtask

    task automatic test_underrun();
        do_reset();
        s_valid = 1; s_data = 16'h1234;
        step();
        s_valid = 0; en = 1;
        for (int i = 0; i < 16; i++) begin
            step();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL underrun_model: cyc %0d got %h want %h", i, obs_vec(), exp_vec());
            end
        end
        checks++;
        if ({a1, a0, ur1, cnt1} !== {16'h8000, 16'h9234, 1'b1, 8'd3}) begin
            errors++; $display("FAIL underrun_end: got a=%h/%h ur=%b cnt=%0d want 8000/9234 1 3",
                               a1, a0, ur1, cnt1);
        end
    endtask

    task automatic test_saturate();
        int n;
        repeat (300 * 4) step();
        checks++;
        if ({cnt1, cnt0, ur1} !== {8'd255, 8'd255, 1'b1}) begin
            errors++; $display("FAIL saturate: got %0d/%0d ur=%b want 255/255 1", cnt1, cnt0, ur1);
        end
        n = 0;
        while (m_phase != 3 && n < 8) begin step(); n++; end
        checks++;
        if (n >= 8) begin
            errors++; $display("FAIL clr_align: model phase never reached 3");
        end
        clr_status = 1;
        step();
        clr_status = 0;
        checks++;
        if ({tick1, ur1, cnt1, ur0, cnt0} !== {1'b1, 1'b0, 8'd0, 1'b0, 8'd0}) begin
            errors++; $display("FAIL clr_priority: got tick=%b ur=%b cnt=%0d ur0=%b cnt0=%0d want 1 0 0 0 0",
                               tick1, ur1, cnt1, ur0, cnt0);
        end
        en = 0;
    endtask

    task automatic test_hold();
        logic [W-1:0] a_snap;
        do_reset();
        s_valid = 1; s_data = 16'hA5A5; en = 1;
        step();
        step();
        en = 0;
        for (int i = 0; i < 4; i++) begin
            s_data = 16'($urandom);
            step();
        end
        a_snap = a1;
        for (int i = 0; i < 10; i++) begin
            acc_sum = 16'($urandom);
            #1;
            checks++;
            if ({b1, b0, s_cin1, s_cin0} !== {acc_sum, acc_sum, 2'b00}) begin
                errors++; $display("FAIL passthrough: got b=%h/%h cin=%b%b want %h 0", b1, b0, s_cin1, s_cin0, acc_sum);
            end
            step();
            checks++;
            if ({tick1, s_ready1, a1} !== {1'b0, 1'b0, a_snap}) begin
                errors++; $display("FAIL hold: cyc %0d got tick=%b rdy=%b a=%h want 0 0 %h", i, tick1, s_ready1, a1, a_snap);
            end
        end
        acc_sum = 16'h1234;
        #1;
        checks++;
        if (b1 !== 16'h1234) begin
            errors++; $display("FAIL b_fixed: got %h want 1234", b1);
        end
        s_valid = 0; en = 1;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL resume_model: cyc %0d got %h want %h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            s_valid    = ($urandom_range(0, 3) != 0);
            s_data     = 16'($urandom);
            en         = ($urandom_range(0, 7) != 0);
            clr_status = ($urandom_range(0, 40) == 0);
            if ($urandom_range(0, 250) == 0) begin
                #2 rst_n = 0;
                #1 rst_n = 1;
            end
            step();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL random_model: cyc %0d got %h want %h", i, obs_vec(), exp_vec());
            end
        end
        s_valid = 0; en = 0; clr_status = 0;
    endtask

    initial begin
        rst_n = 0;
        step();
        step();
        rst_n = 1;
        test_reset();
        test_ordered();
        test_full_pop();
        test_underrun();
        test_saturate();
        test_hold();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
